bitstream_decoder: RTL

Serial-to-parallel receiver for the packet bitstream produced by the team's bitstream encoder. It samples a one-bit serial input qualified by a frame signal and a per-bit enable, checks the SYNC byte, and captures and checks the PID byte. It then captures ADDR/ENDP or DATA according to the PID, and presents the decoded fields in parallel with a one-cycle valid pulse. It sits at the receiving end of the link, feeding the protocol handler.

---
 rtl/bitstream_decoder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/bitstream_decoder.sv
// bitstream_decoder
//   Serial-to-parallel receiver for the encoder's packet bitstream. It checks
//   SYNC, captures and checks the PID byte, then captures ADDR/ENDP (OUT/IN)
//   or DATA (DATA0). It presents the decoded fields with a one-cycle
//   pkt_valid pulse, or reports a one-cycle err pulse.
//
// Input qualification:
//   A bit is taken only on a posedge where sending=1 and bit_en=1.
//   sending=1 with bit_en=0 is a pause: no state, counter or shift change.
//   sending=0 marks the gap between packets.
//   No ready signal exists; the decoder accepts every qualified bit.
//
// Ports
//   clk        system clock, all state on posedge
//   rst_L      synchronous active-low reset
//   inb        serial data bit (MSB of each field first)
//   sending    frame qualifier
//   bit_en     bit qualifier (low = pause)
//   pid        decoded PID (updated on pkt_valid)
//   addr       decoded address (updated on pkt_valid of OUT/IN)
//   endp       decoded endpoint (updated on pkt_valid of OUT/IN)
//   data       decoded payload (updated on pkt_valid of DATA0)
//   pkt_valid  one-cycle pulse, fields valid
//   err        one-cycle pulse, bad SYNC/PID, unknown PID, or early frame end
//   busy       high whenever the FSM is not in IDLE
module bitstream_decoder #(
  parameter logic [7:0] SYNC_PAT  = 8'b0000_0001,
  parameter int         DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_L,
  input  logic                 inb,
  input  logic                 sending,
  input  logic                 bit_en,
  output logic [3:0]           pid,
  output logic [6:0]           addr,
  output logic [3:0]           endp,
  output logic [DATA_BITS-1:0] data,
  output logic                 pkt_valid,
  output logic                 err,
  output logic                 busy
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_PID   = 3'd2,
    ST_ADDR  = 3'd3,
    ST_ENDP  = 3'd4,
    ST_DATA  = 3'd5,
    ST_DRAIN = 3'd6
  } state_t;

  state_t               state, state_n;
  logic [6:0]           cnt, cnt_n;
  logic [DATA_BITS-1:0] sr, sr_n;         // working shift register
  logic [3:0]           pid_w, pid_w_n;   // PID held until the packet completes
  logic [6:0]           addr_w, addr_w_n; // ADDR held until ENDP completes
  logic [3:0]           pid_n, endp_n;
  logic [6:0]           addr_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 pkt_valid_n, err_n, busy_n;
  logic                 take;
  logic [DATA_BITS-1:0] shifted;
  logic [7:0]           byte8;

  // Counter value on which the current field's final bit arrives.
  function automatic logic [6:0] field_last(input state_t s);
    case (s)
      ST_SYNC: field_last = 7'd7;
      ST_PID:  field_last = 7'd7;
      ST_ADDR: field_last = 7'd6;
      ST_ENDP: field_last = 7'd3;
      ST_DATA: field_last = 7'(DATA_BITS - 1);
      default: field_last = 7'd0;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sr_n        = sr;
    pid_w_n     = pid_w;
    addr_w_n    = addr_w;
    pid_n       = pid;
    addr_n      = addr;
    endp_n      = endp;
    data_n      = data;
    pkt_valid_n = 1'b0;
    err_n       = 1'b0;
    take        = sending & bit_en;
    // The bit being taken is already merged, so field checks see the full field.
    shifted     = {sr[DATA_BITS-2:0], inb};
    byte8       = shifted[7:0];

    unique case (state)
      ST_IDLE: begin
        cnt_n = 7'd0;
        if (sending) begin
          state_n = ST_SYNC;
          if (bit_en) begin
            sr_n  = shifted;
            cnt_n = 7'd1;
          end
        end
      end

      ST_SYNC, ST_PID, ST_ADDR, ST_ENDP, ST_DATA: begin
        if (!sending) begin
          // Frame ended before the field completed.
          err_n   = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = 7'd0;
        end else if (take) begin
          sr_n = shifted;
          if (cnt == field_last(state)) begin
            cnt_n = 7'd0;
            // A completed packet or an error always lands in DRAIN because
            // sending is necessarily high on the cycle a bit is taken.
            unique case (state)
              ST_SYNC: begin
                if (byte8 == SYNC_PAT) begin
                  state_n = ST_PID;
                end else begin
                  err_n   = 1'b1;
                  state_n = ST_DRAIN;
                end
              end
              ST_PID: begin
                if (byte8[3:0] != ~byte8[7:4]) begin
                  err_n   = 1'b1;
                  state_n = ST_DRAIN;
                end else begin
                  case (byte8[7:4])
                    PID_ACK, PID_NAK: begin
                      pid_n       = byte8[7:4];
                      pkt_valid_n = 1'b1;
                      state_n     = ST_DRAIN;
                    end
                    PID_OUT, PID_IN: begin
                      pid_w_n = byte8[7:4];
                      state_n = ST_ADDR;
                    end
                    PID_DATA0: begin
                      pid_w_n = byte8[7:4];
                      state_n = ST_DATA;
                    end
                    default: begin
                      err_n   = 1'b1;
                      state_n = ST_DRAIN;
                    end
                  endcase
                end
              end
              ST_ADDR: begin
                addr_w_n = shifted[6:0];
                state_n  = ST_ENDP;
              end
              ST_ENDP: begin
                pid_n       = pid_w;
                addr_n      = addr_w;
                endp_n      = shifted[3:0];
                pkt_valid_n = 1'b1;
                state_n     = ST_DRAIN;
              end
              default: begin // ST_DATA
                pid_n       = pid_w;
                data_n      = shifted;
                pkt_valid_n = 1'b1;
                state_n     = ST_DRAIN;
              end
            endcase
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
      end

      ST_DRAIN: begin
        cnt_n = 7'd0;
        if (!sending) state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = 7'd0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state     <= ST_IDLE;
      cnt       <= 7'd0;
      sr        <= '0;
      pid_w     <= 4'd0;
      addr_w    <= 7'd0;
      pid       <= 4'd0;
      addr      <= 7'd0;
      endp      <= 4'd0;
      data      <= '0;
      pkt_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sr        <= sr_n;
      pid_w     <= pid_w_n;
      addr_w    <= addr_w_n;
      pid       <= pid_n;
      addr      <= addr_n;
      endp      <= endp_n;
      data      <= data_n;
      pkt_valid <= pkt_valid_n;
      err       <= err_n;
      busy      <= busy_n;
    end
  end

endmodule
